// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: round-robin sequencer sharing one combinational ALU between two requesters
module alu_arbiter_seq #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_ctrl_i,
  input  logic [WIDTH-1:0] req0_data0_i,
  input  logic [WIDTH-1:0] req0_data1_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_ctrl_i,
  input  logic [WIDTH-1:0] req1_data0_i,
  input  logic [WIDTH-1:0] req1_data1_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_id_o,
  output logic [WIDTH-1:0] resp_result_o,
  output logic             resp_err_o,
  output logic [2:0]       alu_ctrl_o,
  output logic [WIDTH-1:0] alu_data0_o,
  output logic [WIDTH-1:0] alu_data1_o,
  input  logic [WIDTH-1:0] alu_result_i
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           r_state;
  logic             r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             w_gnt;
  logic             w_acc;
  logic             w_ill;
  logic             w_dz;
  logic [2:0]       w_ctrl;
  logic [WIDTH-1:0] w_d0;
  logic [WIDTH-1:0] w_d1;
  // On a tie the requester opposite the last grant wins
  always_comb begin
    w_gnt        = (req0_valid_i && req1_valid_i) ? ~r_ptr : req1_valid_i;
    req0_ready_o = (r_state == IDLE) && req0_valid_i && !w_gnt;
    req1_ready_o = (r_state == IDLE) && req1_valid_i && w_gnt;
    w_acc        = req0_ready_o || req1_ready_o;
    w_ctrl       = w_gnt ? req1_ctrl_i  : req0_ctrl_i;
    w_d0         = w_gnt ? req1_data0_i : req0_data0_i;
    w_d1         = w_gnt ? req1_data1_i : req0_data1_i;
    w_ill        = w_ctrl > 3'd4;
    w_dz         = (w_ctrl == 3'd3 || w_ctrl == 3'd4) && w_d1 == '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_ptr         <= 1'b1;
      r_cnt         <= '0;
      resp_valid_o  <= 1'b0;
      resp_id_o     <= 1'b0;
      resp_result_o <= '0;
      resp_err_o    <= 1'b0;
      alu_ctrl_o    <= '0;
      alu_data0_o   <= '0;
      alu_data1_o   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_ptr       <= w_gnt;
          resp_id_o   <= w_gnt;
          alu_ctrl_o  <= w_ctrl;
          alu_data0_o <= w_d0;
          alu_data1_o <= w_d1;
          r_cnt       <= CW'(SETTLE_CYCLES - 1);
          // Rejected ops skip the ALU wait; the ALU is still driven but ignored
          if (w_ill || w_dz) begin
            r_state       <= RESP;
            resp_valid_o  <= 1'b1;
            resp_err_o    <= 1'b1;
            resp_result_o <= w_ill ? '0 : '1;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: if (r_cnt == '0) begin
          r_state       <= RESP;
          resp_valid_o  <= 1'b1;
          resp_err_o    <= 1'b0;
          resp_result_o <= alu_result_i;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
        RESP: if (resp_ready_i) begin
          r_state      <= IDLE;
          resp_valid_o <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
